// File: rtl/register_file_mp_if.sv
// ----------------------------------------------------------------------------
// register_file_mp_if
// Bundles the read, write and reserve ports of the multi-port register file.
//
// Parameters: WIDTH (data bits), DEPTH (registers), NREAD, NWRITE.
// Signals:
//   rsel    NREAD*AW      read selects, port i = rsel[i*AW +: AW]
//   rdat    NREAD*WIDTH   read data,    port i = rdat[i*WIDTH +: WIDTH]
//   rbusy   NREAD         busy bit of the register selected by read port i
//   wen     NWRITE        write enables
//   wsel    NWRITE*AW     write selects
//   wdat    NWRITE*WIDTH  write data
//   rsv_en  1             reserve request (mark rsv_sel busy)
//   rsv_sel AW            register to reserve
// Modports: master drives selects/writes/reserve; slave is the register file.
// ----------------------------------------------------------------------------
interface register_file_mp_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1
) ();
    localparam int AW = $clog2(DEPTH);

    logic [NREAD*AW-1:0]     rsel;
    logic [NREAD*WIDTH-1:0]  rdat;
    logic [NREAD-1:0]        rbusy;
    logic [NWRITE-1:0]       wen;
    logic [NWRITE*AW-1:0]    wsel;
    logic [NWRITE*WIDTH-1:0] wdat;
    logic                    rsv_en;
    logic [AW-1:0]           rsv_sel;

    modport master (
        output rsel, wen, wsel, wdat, rsv_en, rsv_sel,
        input  rdat, rbusy
    );

    modport slave (
        input  rsel, wen, wsel, wdat, rsv_en, rsv_sel,
        output rdat, rbusy
    );
endinterface

// File: rtl/register_file_mp.sv
// ----------------------------------------------------------------------------
// register_file_mp
// Parametrised multi-port integer register file with a per-register busy
// scoreboard (reserve at issue, clear at writeback).
//
// Ports:
//   CLK  in  clock, all state updates on posedge
//   RST  in  synchronous reset, active-high; clears registers and busy bits
//   bus  register_file_mp_if.slave: combinational reads (rsel/rdat/rbusy),
//        synchronous writes (wen/wsel/wdat), reserve (rsv_en/rsv_sel)
//
// Parameters: WIDTH, DEPTH (power of two), NREAD, NWRITE, ZERO_REG
//   (1 = register 0 reads zero, ignores writes and reserves).
//
// Optional feature, macro RF_BYPASS_EN: when defined, a read port whose select
// matches a same-cycle write returns that write data (highest-numbered port
// wins) and the next-state busy bit. Undefined: reads return current state.
// ----------------------------------------------------------------------------
module register_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1
) (
    input logic               CLK,
    input logic               RST,
    register_file_mp_if.slave bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0]       regs   [DEPTH];
    logic [DEPTH-1:0]       busy;

    // Per-register view of this cycle's writes after collision resolution.
    logic [DEPTH-1:0]       wr_hit;
    logic [WIDTH-1:0]       wr_val [DEPTH];
    logic [DEPTH-1:0]       busy_nxt;

    logic [NREAD*WIDTH-1:0] rdat_c;
    logic [NREAD-1:0]       rbusy_c;

    // Later ports overwrite earlier ones, so the highest-numbered port wins a
    // collision on the same register.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_hit = '0;
        for (int r = 0; r < DEPTH; r++) wr_val[r] = '0;
        for (int j = 0; j < NWRITE; j++) begin
            if (bus.wen[j]) begin
                wr_hit[bus.wsel[j*AW +: AW]] = 1'b1;
                wr_val[bus.wsel[j*AW +: AW]] = bus.wdat[j*WIDTH +: WIDTH];
            end
        end
        if (HAS_ZERO) begin
            wr_hit[0] = 1'b0;
            wr_val[0] = '0;
        end
    end

    // Writeback clears busy; a reserve in the same cycle wins because it
    // names a newer producer for the register.
    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (bus.rsv_en && !(HAS_ZERO && bus.rsv_sel == '0))
            busy_nxt[bus.rsv_sel] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the register array is reset explicitly because software
            // relies on every register reading zero after reset; this costs
            // a reset path on every storage bit, so it is not a free choice.
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
            busy <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            for (int r = 0; r < DEPTH; r++) begin
                if (wr_hit[r]) regs[r] <= wr_val[r];
            end
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rdat_c  = '0;
        rbusy_c = '0;
        for (int i = 0; i < NREAD; i++) begin
            rdat_c[i*WIDTH +: WIDTH] = regs[bus.rsel[i*AW +: AW]];
            rbusy_c[i]               = busy[bus.rsel[i*AW +: AW]];
`ifdef RF_BYPASS_EN
            if (wr_hit[bus.rsel[i*AW +: AW]]) begin
                rdat_c[i*WIDTH +: WIDTH] = wr_val[bus.rsel[i*AW +: AW]];
                rbusy_c[i]               = busy_nxt[bus.rsel[i*AW +: AW]];
            end
`endif
            // Register 0 reads as zero even before its storage has been reset.
            if (HAS_ZERO && bus.rsel[i*AW +: AW] == '0) begin
                rdat_c[i*WIDTH +: WIDTH] = '0;
                rbusy_c[i]               = 1'b0;
            end
        end
    end

    assign bus.rdat  = rdat_c;
    assign bus.rbusy = rbusy_c;
endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = $clog2(DEPTH);
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // bus drives the ZERO_REG=1 instance, bus_z the ZERO_REG=0 instance.
    register_file_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE)) bus ();
    register_file_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE)) bus_z ();

    register_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE), .ZERO_REG(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    register_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE), .ZERO_REG(0)) dut_z (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_z.slave)
    );

    typedef struct {
        string            tag;
        bit               alt;   // 1: compare against dut_z
        int               port;
        bit               is_busy;
        logic [WIDTH-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic idle();
        bus.wen = '0;   bus.wsel = '0;   bus.wdat = '0;
        bus.rsv_en = 1'b0;   bus.rsv_sel = '0;
        bus_z.wen = '0; bus_z.wsel = '0; bus_z.wdat = '0;
        bus_z.rsv_en = 1'b0; bus_z.rsv_sel = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wr(input int port, input logic [AW-1:0] sel, input logic [WIDTH-1:0] d);
        bus.wen[port]              = 1'b1;
        bus.wsel[port*AW +: AW]    = sel;
        bus.wdat[port*WIDTH +: WIDTH] = d;
    endtask

    task automatic rsv(input logic [AW-1:0] sel);
        bus.rsv_en  = 1'b1;
        bus.rsv_sel = sel;
    endtask

    // Select a register on a read port and queue the expected data and busy.
    task automatic rd(input string tag, input bit alt, input int port, input logic [AW-1:0] sel,
                      input logic [WIDTH-1:0] exp_d, input bit exp_b);
        exp_t e;
        if (alt) bus_z.rsel[port*AW +: AW] = sel;
        else     bus.rsel[port*AW +: AW]   = sel;
        e.tag = {tag, "_dat"}; e.alt = alt; e.port = port; e.is_busy = 1'b0; e.exp = exp_d;
        sb.push_back(e);
        e.tag = {tag, "_busy"}; e.is_busy = 1'b1; e.exp = {{(WIDTH-1){1'b0}}, exp_b};
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic compare();
        exp_t             e;
        logic [WIDTH-1:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_busy)
                obs = {{(WIDTH-1){1'b0}}, (e.alt ? bus_z.rbusy[e.port] : bus.rbusy[e.port])};
            else
                obs = e.alt ? bus_z.rdat[e.port*WIDTH +: WIDTH] : bus.rdat[e.port*WIDTH +: WIDTH];
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        bus.rsel = '0;
        bus_z.rsel = '0;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;

        // Reset state
        rd("rst_r0", 0, 0, 5'd0, 32'h0, 1'b0);
        rd("rst_r31", 0, 1, 5'd31, 32'h0, 1'b0);
        compare();

        // 1. Write reg5, then reset: the write is lost
        wr(0, 5'd5, 32'hDEAD_BEEF);
        step();
        idle();
        RST = 1'b1;
        rd("pre_rst_r5", 0, 0, 5'd5, 32'hDEAD_BEEF, 1'b0);
        compare();
        step();
        RST = 1'b0;
        rd("post_rst_r5", 0, 0, 5'd5, 32'h0, 1'b0);
        rd("post_rst_r7", 0, 1, 5'd7, 32'h0, 1'b0);
        compare();

        // 2. Write reg7; same-cycle read depends on bypass
        wr(0, 5'd7, 32'h1234);
        rd("rdw_r7", 0, 0, 5'd7, BYP ? 32'h1234 : 32'h0, 1'b0);
        compare();
        step();
        idle();
        rd("wr_r7", 0, 0, 5'd7, 32'h1234, 1'b0);
        rd("wr_r7_p1", 0, 1, 5'd7, 32'h1234, 1'b0);
        compare();

        // 3. Write collision on reg3: port 1 wins
        wr(0, 5'd3, 32'hAAAA);
        wr(1, 5'd3, 32'h5555);
        rd("col_rdw_r3", 0, 1, 5'd3, BYP ? 32'h5555 : 32'h0, 1'b0);
        compare();
        step();
        idle();
        rd("col_r3_p0", 0, 0, 5'd3, 32'h5555, 1'b0);
        rd("col_r3_p1", 0, 1, 5'd3, 32'h5555, 1'b0);
        compare();

        // 4. Register 0 with and without ZERO_REG
        wr(0, 5'd0, 32'hFFFF_FFFF);
        rsv(5'd0);
        bus_z.wen[0] = 1'b1;
        bus_z.wsel[0 +: AW] = 5'd0;
        bus_z.wdat[0 +: WIDTH] = 32'hFFFF_FFFF;
        bus_z.rsv_en = 1'b1;
        bus_z.rsv_sel = 5'd0;
        step();
        idle();
        rd("zero_r0", 0, 0, 5'd0, 32'h0, 1'b0);
        rd("nozero_r0", 1, 0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        compare();

        // 5. Busy sequence on reg9
        rsv(5'd9);
        step();
        idle();
        rd("busy_rsv_r9", 0, 0, 5'd9, 32'h0, 1'b1);
        compare();
        wr(1, 5'd9, 32'h99);
        step();
        idle();
        rd("busy_wb_r9", 0, 0, 5'd9, 32'h99, 1'b0);
        compare();
        wr(0, 5'd9, 32'h100);
        rsv(5'd9);
        rd("busy_rdw_r9", 0, 1, 5'd9, BYP ? 32'h100 : 32'h99, BYP);
        compare();
        step();
        idle();
        rd("busy_both_r9", 0, 1, 5'd9, 32'h100, 1'b1);
        compare();

        // 6. Reset beats a same-cycle write and reserve on reg4
        wr(0, 5'd4, 32'h11);
        rsv(5'd4);
        step();
        idle();
        rd("pre6_r4", 0, 0, 5'd4, 32'h11, 1'b1);
        compare();
        RST = 1'b1;
        wr(0, 5'd4, 32'h77);
        rsv(5'd4);
        step();
        RST = 1'b0;
        idle();
        rd("rst_pri_r4", 0, 0, 5'd4, 32'h0, 1'b0);
        rd("rst_pri_r9", 0, 1, 5'd9, 32'h0, 1'b0);
        compare();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
